// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    STK  = 2'd2,
    DMA  = 2'd3
  } tag_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned MAX_WAIT_DEF  = 8;
  localparam int unsigned BURST_MAX_DEF = 16;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection: burst exclusivity, DMA starvation override, stk > cpu > dma.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic       en,
  input  logic       burst,
  input  logic       force_dma,
  input  logic       cpu_req,
  input  logic       stk_req,
  input  logic       dma_req,
  output logic [2:0] gnt,   // {dma, stk, cpu}
  output tag_e       tag
);

  always_comb begin
    gnt = '0;
    tag = NONE;
    if (en) begin
      if (burst || force_dma) begin
        if (dma_req) begin
          gnt = 3'b100;
          tag = DMA;
        end
      end else if (stk_req) begin
        gnt = 3'b010;
        tag = STK;
      end else if (cpu_req) begin
        gnt = 3'b001;
        tag = CPU;
      end else if (dma_req) begin
        gnt = 3'b100;
        tag = DMA;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous data RAM port between CPU, stack engine and DMA,
// with registered RAM drive and tagged read-data return.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          stk_req,
  input  logic          stk_we,
  input  logic [AW-1:0] stk_addr,
  input  logic [DW-1:0] stk_wdata,
  output logic          stk_gnt,
  output logic          stk_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_last,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  state_e        state, state_nx;
  logic [7:0]    wait_cnt, wait_nx;
  logic [7:0]    burst_cnt, burst_nx;
  logic [7:0]    burst_inc;
  logic          force_dma;
  logic [2:0]    gnt;
  tag_e          pick_tag;
  tag_e          tag_q;
  logic          acc;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign force_dma = dma_req && (wait_cnt == 8'(MAX_WAIT));

  ram_arb_pick u_pick (
    .en        (!rst),
    .burst     (state == BURST),
    .force_dma (force_dma),
    .cpu_req   (cpu_req),
    .stk_req   (stk_req),
    .dma_req   (dma_req),
    .gnt       (gnt),
    .tag       (pick_tag)
  );

  assign cpu_gnt = gnt[0];
  assign stk_gnt = gnt[1];
  assign dma_gnt = gnt[2];
  assign acc     = |gnt;
  assign rdata   = ram_rdata;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[2]) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end else if (gnt[1]) begin
      sel_we    = stk_we;
      sel_addr  = stk_addr;
      sel_wdata = stk_wdata;
    end else if (gnt[0]) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
  end

  assign burst_inc = burst_cnt + 8'd1;

  always_comb begin
    state_nx = state;
    burst_nx = burst_cnt;
    wait_nx  = wait_cnt;

    if (dma_gnt)
      wait_nx = '0;
    else if (dma_req && (wait_cnt < 8'(MAX_WAIT)))
      wait_nx = wait_cnt + 8'd1;

    unique case (state)
      IDLE: begin
        // A single-word burst limit never needs the exclusive state.
        if (dma_gnt && !dma_last && (BURST_MAX > 1)) begin
          state_nx = BURST;
          burst_nx = 8'd1;
        end
      end
      BURST: begin
        if (dma_gnt) begin
          burst_nx = burst_inc;
          if (dma_last || (burst_inc >= 8'(BURST_MAX))) begin
            state_nx = IDLE;
            burst_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      tag_q      <= NONE;
      cpu_rvalid <= 1'b0;
      stk_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      burst_cnt <= burst_nx;
      ram_en    <= acc;
      ram_we    <= acc && sel_we;
      if (acc) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      // Tag rides alongside the RAM drive, then becomes rvalid when data returns.
      tag_q      <= (acc && !sel_we) ? pick_tag : NONE;
      cpu_rvalid <= (tag_q == CPU);
      stk_rvalid <= (tag_q == STK);
      dma_rvalid <= (tag_q == DMA);
    end
  end

endmodule
